// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch stage.
//
// Holds the program counter, issues one-at-a-time instruction memory reads
// over a req/ready handshake and buffers each returned word together with
// its fetch address + 4 in a small FIFO toward decode. A taken-branch
// redirect from execute flushes the buffer and any wrong-path read, including
// one that is still waiting for imem_ready.
//
// Ports:
//   clk, rst_n     - rising-edge clock, asynchronous active-low reset
//   imem_req       - read request valid (held until imem_ready)
//   imem_addr      - word-aligned read address (held until imem_ready)
//   imem_ready     - memory accepts the request; imem_rdata valid same cycle
//   imem_rdata     - instruction word
//   branch_taken   - single-cycle redirect pulse from execute
//   branch_target  - redirect address; bits [1:0] ignored
//   if_valid       - buffer head valid toward decode
//   if_instr       - instruction at buffer head
//   if_pc_plus4    - fetch address of the head word + 4
//   id_ready       - decode accepts the head word
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  input  logic        id_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  // DRAIN waits out a wrong-path request that was pending when the redirect came.
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } entry_t;

  // Redirect addresses are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   target_q, target_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        buf_q [DEPTH];
  entry_t        buf_d [DEPTH];

  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] wr_idx_s;
  logic [31:0]   redirect_s;
  entry_t        new_entry_s;

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  // A redirect hides the head in the same cycle so decode never takes a wrong-path word.
  assign if_valid    = (count_q != {CW{1'b0}}) & ~branch_taken;
  assign if_instr    = buf_q[0].instr;
  assign if_pc_plus4 = buf_q[0].pc_plus4;

  // Handshake decode and buffer occupancy.
  always_comb begin
    accept_s    = req_q & imem_ready;
    // Only right-path data in FETCH is kept; DRAIN returns are discarded.
    push_s      = accept_s & (state_q == ST_FETCH) & ~branch_taken;
    pop_s       = (count_q != {CW{1'b0}}) & id_ready & ~branch_taken;
    redirect_s  = word_align(branch_target);
    new_entry_s = '{instr: imem_rdata, pc_plus4: addr_q + 32'd4};
    // After a pop the tail slides down one slot, so the write lands one lower.
    if (pop_s) begin
      wr_idx_s = count_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      wr_idx_s = count_q;
    end
    if (branch_taken) begin
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    end
  end

  // Shift-register buffer: slot 0 is always the head, so the head is a plain register.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (wr_idx_s == CW'(i))) begin
        buf_d[i] = new_entry_s;
      end else if (pop_s && (i < DEPTH - 1)) begin
        buf_d[i] = buf_q[(i + 1) % DEPTH];
      end else begin
        buf_d[i] = buf_q[i];
      end
    end
  end

  // Request / PC / redirect state machine, next-state and outputs.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    target_d = target_q;
    case (state_q)
      ST_FETCH: begin
        if (branch_taken) begin
          if (req_q && !imem_ready) begin
            // The old request cannot be retracted; remember where to go after it completes.
            state_d  = ST_DRAIN;
            target_d = redirect_s;
            req_d    = 1'b1;
          end else begin
            addr_d = redirect_s;
            req_d  = 1'b1;
          end
        end else if (req_q && !imem_ready) begin
          req_d = 1'b1;
        end else begin
          if (accept_s) begin
            addr_d = addr_q + 32'd4;
          end else begin
            addr_d = addr_q;
          end
          // Nothing is pending after this cycle, so only buffered words count.
          req_d = (count_d < CW'(DEPTH));
        end
      end
      ST_DRAIN: begin
        req_d = 1'b1;
        // The last redirect wins, including one arriving with imem_ready.
        if (branch_taken) begin
          target_d = redirect_s;
        end else begin
          target_d = target_q;
        end
        if (imem_ready) begin
          state_d = ST_FETCH;
          addr_d  = branch_taken ? redirect_s : target_q;
        end else begin
          state_d = ST_DRAIN;
          addr_d  = addr_q;
        end
      end
      default: begin
        state_d = ST_FETCH;
        req_d   = 1'b0;
        addr_d  = addr_q;
      end
    endcase
  end

  // Control and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      target_q <= RESET_PC;
      count_q  <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      count_q  <= count_d;
    end
  end

  // Instruction buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '{instr: 32'h0000_0000, pc_plus4: 32'h0000_0000};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit - self-checking bench for fetch_unit.
// A per-cycle scoreboard tracks right-path fetches (expected address, word,
// pc+4) and compares every delivered head; a vector table and hand-written
// sequences pin exact cycle timing for streaming, backpressure, redirects,
// DRAIN, address wrap and asynchronous reset.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0000_0000;
  logic        id_ready = 1'b0;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc_plus4;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc4;

  assign imem_rdata = imem_addr ^ KEY;
  assign w_rdata    = w_addr ^ KEY;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
    .id_ready(id_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rdata(w_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc_plus4(w_pc4),
    .id_ready(id_ready)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        idr;
    logic        br;
    logic [31:0] tgt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc4;
  } vec_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          delivered = 0;
  logic [31:0] exp_addr = 32'h0000_0000;
  logic        discard = 1'b0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr = 32'h0000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // One clock: settle, run the scoreboard on this cycle's values, advance to next negedge.
  task automatic tick();
    exp_t e;
    logic exp_v;
    #1;
    if (hold_pend) begin
      chk1("hold_req", imem_req, 1'b1);
      chk("hold_addr", imem_addr, hold_addr);
    end
    exp_v = (sb_q.size() != 0) && !branch_taken;
    chk1("sb_if_valid", if_valid, exp_v);
    if (exp_v && id_ready) begin
      e = sb_q.pop_front();
      chk("sb_if_instr", if_instr, e.instr);
      chk("sb_if_pc_plus4", if_pc_plus4, e.pc4);
      delivered++;
    end
    if (imem_req && imem_ready) begin
      if (discard || branch_taken) begin
        discard = 1'b0;
      end else begin
        chk("sb_imem_addr", imem_addr, exp_addr);
        e.instr = exp_addr ^ KEY;
        e.pc4   = exp_addr + 32'd4;
        sb_q.push_back(e);
        exp_addr = exp_addr + 32'd4;
        chk1("no_overflow", sb_q.size() <= DEPTH, 1'b1);
      end
    end
    if (branch_taken) begin
      sb_q.delete();
      exp_addr = {branch_target[31:2], 2'b00};
      if (imem_req && !imem_ready) discard = 1'b1;
    end
    hold_pend = imem_req && !imem_ready;
    hold_addr = imem_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset (asynchronously), check reset values at once, release on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0000);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, 32'h0000_0000);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'h0000_0000);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    chk1("rst_wrap_req", w_req, 1'b0);
    imem_ready = 1'b0; id_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    exp_addr  = 32'h0000_0000;
    discard   = 1'b0;
    hold_pend = 1'b0;
  endtask

  // Hand-written redirect-into-DRAIN sequence; second target optional.
  task automatic drain_seq(input logic dbl, input logic [31:0] final_tgt);
    do_reset();
    imem_ready = 1'b1; id_ready = 1'b1;
    repeat (3) tick();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0040;
    #1;
    chk1("drain_req_c3", imem_req, 1'b1);
    chk("drain_addr_c3", imem_addr, 32'h0000_0008);
    chk1("drain_valid_c3", if_valid, 1'b0);
    tick();
    branch_taken = dbl; branch_target = 32'h0000_0080;
    tick();
    branch_taken = 1'b0;
    #1;
    chk("drain_addr_c5", imem_addr, 32'h0000_0008);
    chk1("drain_valid_c5", if_valid, 1'b0);
    tick();
    imem_ready = 1'b1;
    tick();
    #1;
    chk1("drain_req_c7", imem_req, 1'b1);
    chk("drain_addr_c7", imem_addr, final_tgt);
    chk1("drain_valid_c7", if_valid, 1'b0);
    tick();
    #1;
    chk1("drain_valid_c8", if_valid, 1'b1);
    chk("drain_pc4_c8", if_pc_plus4, final_tgt + 32'd4);
    tick();
  endtask

  initial begin
    vec_t        tbl[18];
    logic [31:0] wexp[5];
    logic [31:0] wpc[5];
    int          d0;

    // rdy idr br tgt | req addr valid pc4
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h4};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h8};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'hC};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'hC};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'hC};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'hC};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'hC};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'hC};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'hC};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h10};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h14};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'h14};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h103, 1'b0, 32'h18,  1'b0, 32'h0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h104};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h108};

    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFF8; wexp[2] = 32'hFFFF_FFFC;
    wexp[3] = 32'h0000_0000; wexp[4] = 32'h0000_0004;
    wpc[0]  = 32'h0; wpc[1] = 32'h0; wpc[2] = 32'hFFFF_FFFC;
    wpc[3]  = 32'h0000_0000; wpc[4] = 32'h0000_0004;

    #3;
    do_reset();

    // Stream, backpressure and redirect with no pending request.
    for (int i = 0; i < 18; i++) begin
      imem_ready = tbl[i].rdy; id_ready = tbl[i].idr;
      branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
      #1;
      chk1($sformatf("tbl%0d_req", i), imem_req, tbl[i].ereq);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk1($sformatf("tbl%0d_valid", i), if_valid, tbl[i].evalid);
      if (tbl[i].evalid) begin
        chk($sformatf("tbl%0d_pc4", i), if_pc_plus4, tbl[i].epc4);
        chk($sformatf("tbl%0d_instr", i), if_instr, (tbl[i].epc4 - 32'd4) ^ KEY);
      end
      tick();
    end

    // Redirect into DRAIN, then last-redirect-wins.
    drain_seq(1'b0, 32'h0000_0040);
    drain_seq(1'b1, 32'h0000_0080);

    // Reset mid-request: request at 0x88 pending when rst_n falls between edges.
    imem_ready = 1'b0;
    #2;
    do_reset();

    // PC wrap at the top of the address space.
    imem_ready = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("wrap%0d_addr", i), w_addr, wexp[i]);
      if (i >= 2) begin
        chk1($sformatf("wrap%0d_valid", i), w_valid, 1'b1);
        chk($sformatf("wrap%0d_pc4", i), w_pc4, wpc[i]);
      end
      tick();
    end

    // Random traffic under the scoreboard.
    for (int i = 0; i < 300; i++) begin
      imem_ready    = ($urandom_range(0, 3) != 0);
      id_ready      = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = $urandom;
      tick();
    end

    // Flow must resume at full rate once both sides are ready.
    imem_ready = 1'b1; id_ready = 1'b1; branch_taken = 1'b0;
    d0 = delivered;
    repeat (8) tick();
    chk1("liveness", (delivered - d0) >= 5, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
